pc_sequencer: RTL and testbench

- Parametrised program-counter unit for the fetch stage, replacing the plain stall-gated PC register.
- Loads the start address from a reset vector in instruction memory and advances by one or two words per instruction.
- Accepts redirects (branch/jump/flush) from later stages, overriding stall.
- Takes interrupts: saves the return PC and loads an interrupt vector, all through a small vector-fetch FSM.

---
 rtl/pc_sequencer_pkg.sv | 23 ++
 rtl/pc_sequencer_vector_loader.sv | 51 +++++
 rtl/pc_sequencer.sv | 119 +++++++++++
 tb/tb_pc_sequencer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared types and sizing helpers for the fetch-stage program-counter sequencer.
// Vector words are assembled least-significant word first.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    RUN   = 2'd1,
    ILOAD = 2'd2
  } pc_state_e;

  localparam int unsigned RST_VEC_DEFAULT = 0;
  localparam int unsigned INT_VEC_DEFAULT = 2;

  function automatic int unsigned vec_words(input int unsigned addr_w, input int unsigned mem_w);
    return addr_w / mem_w;
  endfunction

  // Index must be able to hold NW itself, which marks "all reads issued".
  function automatic int unsigned vec_idx_w(input int unsigned nw);
    return $clog2(nw + 1);
  endfunction

endpackage

// File: rtl/pc_sequencer_vector_loader.sv
// NW-word vector read engine: issues base+k reads while active, then reports
// which word is on the read-data bus one cycle later and when the last one lands.
module pc_vector_loader
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned MEM_W  = 16,
  localparam int unsigned NW    = vec_words(ADDR_W, MEM_W),
  localparam int unsigned IDX_W = vec_idx_w(NW)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_active,
  input  logic [ADDR_W-1:0] i_base,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic              o_cap,
  output logic [IDX_W-1:0]  o_cap_idx,
  output logic              o_done
);

  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] r_cap_idx;
  logic             r_cap;
  logic             w_issue;

  assign w_issue   = i_active && (r_idx < IDX_W'(NW));
  // Gated by rst_n so the strobe is quiet while reset is held.
  assign o_rd_en   = w_issue && rst_n;
  assign o_rd_addr = i_base + ADDR_W'(r_idx);
  assign o_cap     = r_cap;
  assign o_cap_idx = r_cap_idx;
  assign o_done    = r_cap && (r_cap_idx == IDX_W'(NW - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx     <= '0;
      r_cap_idx <= '0;
      r_cap     <= 1'b0;
    end else begin
      r_cap <= w_issue;
      if (w_issue) begin
        r_cap_idx <= r_idx;
        r_idx     <= r_idx + 1'b1;
      end else if (o_done) begin
        r_idx <= '0;
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: reset/interrupt vector load, step/stall/wide,
// redirect override and interrupt entry with saved return address.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned       ADDR_W  = 32,
  parameter int unsigned       MEM_W   = 16,
  parameter int unsigned       STEP    = 1,
  parameter logic [ADDR_W-1:0] RST_VEC = ADDR_W'(RST_VEC_DEFAULT),
  parameter logic [ADDR_W-1:0] INT_VEC = ADDR_W'(INT_VEC_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              wide,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  input  logic              int_req,
  output logic              vec_rd_en,
  output logic [ADDR_W-1:0] vec_rd_addr,
  input  logic [MEM_W-1:0]  vec_rd_data,
  output logic [ADDR_W-1:0] pc,
  output logic              pc_valid,
  output logic [ADDR_W-1:0] epc,
  output logic              int_ack
);

  localparam int unsigned NW    = vec_words(ADDR_W, MEM_W);
  localparam int unsigned IDX_W = vec_idx_w(NW);

  pc_state_e         r_state;
  pc_state_e         w_state_next;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_next;
  logic [ADDR_W-1:0] r_epc;
  logic [ADDR_W-1:0] w_epc_next;
  logic              r_int_pend;
  logic              w_int_pend_next;
  logic              r_int_ack;
  logic              w_take;
  logic [ADDR_W-1:0] w_step;
  logic [ADDR_W-1:0] w_base;
  logic              w_ld_cap;
  logic [IDX_W-1:0]  w_ld_cap_idx;
  logic              w_ld_done;

  assign w_base = (r_state == ILOAD) ? INT_VEC : RST_VEC;
  assign w_step = wide ? ADDR_W'(2 * STEP) : ADDR_W'(STEP);

  pc_vector_loader #(
    .ADDR_W (ADDR_W),
    .MEM_W  (MEM_W)
  ) u_loader (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_active  (r_state != RUN),
    .i_base    (w_base),
    .o_rd_en   (vec_rd_en),
    .o_rd_addr (vec_rd_addr),
    .o_cap     (w_ld_cap),
    .o_cap_idx (w_ld_cap_idx),
    .o_done    (w_ld_done)
  );

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_epc_next   = r_epc;
    w_take       = 1'b0;
    case (r_state)
      RUN: begin
        // Redirect wins over everything; a pending interrupt waits for a free cycle.
        if (redirect_valid) begin
          w_pc_next = redirect_addr;
        end else if (r_int_pend && !stall) begin
          w_take       = 1'b1;
          w_epc_next   = r_pc;
          w_state_next = ILOAD;
        end else if (!stall) begin
          w_pc_next = r_pc + w_step;
        end
      end
      default: begin
        for (int i = 0; i < int'(NW); i++) begin
          if (w_ld_cap && (w_ld_cap_idx == IDX_W'(i))) begin
            w_pc_next[i*MEM_W +: MEM_W] = vec_rd_data;
          end
        end
        if (w_ld_done) begin
          w_state_next = RUN;
        end
      end
    endcase
    // A request arriving while one is being taken stays pending for the next round.
    w_int_pend_next = (r_int_pend && !w_take) || int_req;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= LOAD;
      r_pc       <= '0;
      r_epc      <= '0;
      r_int_pend <= 1'b0;
      r_int_ack  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_epc      <= w_epc_next;
      r_int_pend <= w_int_pend_next;
      r_int_ack  <= w_take;
    end
  end

  assign pc       = r_pc;
  assign epc      = r_epc;
  assign pc_valid = (r_state == RUN);
  assign int_ack  = r_int_ack;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scoreboard bench for pc_sequencer: each stimulus cycle queues the
// hand-computed outputs for that cycle; a negedge monitor pops and compares.
module tb_pc_sequencer;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        wide;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        int_req;
  logic        vec_rd_en;
  logic [31:0] vec_rd_addr;
  logic [15:0] vec_rd_data;
  logic [31:0] pc;
  logic        pc_valid;
  logic [31:0] epc;
  logic        int_ack;

  pc_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .wide           (wide),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .int_req        (int_req),
    .vec_rd_en      (vec_rd_en),
    .vec_rd_addr    (vec_rd_addr),
    .vec_rd_data    (vec_rd_data),
    .pc             (pc),
    .pc_valid       (pc_valid),
    .epc            (epc),
    .int_ack        (int_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector memory with one-cycle registered read.
  logic [15:0] mem [16];
  always @(posedge clk) begin
    if (vec_rd_en) vec_rd_data <= mem[vec_rd_addr[3:0]];
  end

  typedef struct {
    bit          chk_pc;
    logic [31:0] pc;
    bit          vld;
    bit          ack;
    logic [31:0] epc;
    bit          rden;
    logic [31:0] rda;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc_n = 0;
  bit   armed = 1'b0;
  exp_t mon_e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, req, cyc_n);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL queue_underflow: got empty queue, required an entry (cycle %0d)", cyc_n);
      end else begin
        mon_e = exp_q.pop_front();
        $display("cycle %0d: rst_n=%b pc=%h valid=%b epc=%h ack=%b rd_en=%b rd_addr=%h",
                 cyc_n, rst_n, pc, pc_valid, epc, int_ack, vec_rd_en, vec_rd_addr);
        chk("pc_valid", 32'(pc_valid), 32'(mon_e.vld));
        chk("int_ack", 32'(int_ack), 32'(mon_e.ack));
        chk("epc", epc, mon_e.epc);
        chk("vec_rd_en", 32'(vec_rd_en), 32'(mon_e.rden));
        if (mon_e.rden) chk("vec_rd_addr", vec_rd_addr, mon_e.rda);
        if (mon_e.chk_pc) chk("pc", pc, mon_e.pc);
      end
      cyc_n++;
    end
  end

  task automatic push(input bit c, input logic [31:0] p, input bit v, input bit a,
                      input logic [31:0] e, input bit r, input logic [31:0] ra);
    exp_t x;
    x.chk_pc = c; x.pc = p; x.vld = v; x.ack = a; x.epc = e; x.rden = r; x.rda = ra;
    exp_q.push_back(x);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Apply inputs for this cycle and queue the outputs this cycle must show.
  task automatic cyc(input bit st, input bit wd, input bit rv, input logic [31:0] ra, input bit ir,
                     input bit v, input logic [31:0] p, input bit a, input logic [31:0] e,
                     input bit rden, input logic [31:0] rda);
    stall = st; wide = wd; redirect_valid = rv; redirect_addr = ra; int_req = ir;
    push(v, p, v, a, e, rden, rda);
    tick();
  endtask

  task automatic reset_vector_seq;
    cyc(0,0,0,0,0, 0,0,0,0, 1,0);
    cyc(0,0,0,0,0, 0,0,0,0, 1,1);
    cyc(0,0,0,0,0, 0,0,0,0, 0,0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem[0] = 16'h1234; mem[1] = 16'h00AB; mem[2] = 16'h0300; mem[3] = 16'h0000;
    rst_n = 1'b0; stall = 0; wide = 0; redirect_valid = 0; redirect_addr = '0; int_req = 0;
    @(posedge clk); #1;
    armed = 1'b1;
    push(1, 0, 0, 0, 0, 0, 0);  // held in reset
    tick();
    rst_n = 1'b1;
    reset_vector_seq();
    // run / step / stall / wide
    cyc(0,0,1,'h100,0,  1,'h00AB1234,0,0, 0,0);
    cyc(0,0,0,0,0,      1,'h100,0,0, 0,0);
    cyc(0,0,0,0,0,      1,'h101,0,0, 0,0);
    cyc(1,0,0,0,0,      1,'h102,0,0, 0,0);
    cyc(1,0,0,0,0,      1,'h102,0,0, 0,0);
    cyc(0,1,0,0,0,      1,'h102,0,0, 0,0);
    cyc(0,0,0,0,0,      1,'h104,0,0, 0,0);
    // redirect beats stall
    cyc(1,0,1,'h2000,0, 1,'h105,0,0, 0,0);
    cyc(1,0,0,0,0,      1,'h2000,0,0, 0,0);
    cyc(1,0,1,'h50,0,   1,'h2000,0,0, 0,0);
    // interrupt held off by stall
    cyc(1,0,0,0,1,      1,'h50,0,0, 0,0);
    cyc(1,0,0,0,0,      1,'h50,0,0, 0,0);
    cyc(1,0,0,0,0,      1,'h50,0,0, 0,0);
    cyc(0,0,0,0,0,      1,'h50,0,0, 0,0);
    cyc(0,0,0,0,0,      0,0,1,'h50, 1,2);
    cyc(0,0,0,0,0,      0,0,0,'h50, 1,3);
    cyc(0,0,0,0,0,      0,0,0,'h50, 0,0);
    // interrupt and redirect in the same cycle
    cyc(0,0,1,'h40,1,   1,'h300,0,'h50, 0,0);
    cyc(0,0,0,0,0,      1,'h40,0,'h50, 0,0);
    cyc(0,0,0,0,0,      0,0,1,'h40, 1,2);
    cyc(0,0,0,0,0,      0,0,0,'h40, 1,3);
    cyc(0,0,0,0,0,      0,0,0,'h40, 0,0);
    // wrap at all-ones
    cyc(0,0,1,'hFFFFFFFF,0, 1,'h300,0,'h40, 0,0);
    cyc(0,0,0,0,0,      1,'hFFFFFFFF,0,'h40, 0,0);
    cyc(0,1,0,0,0,      1,'h0,0,'h40, 0,0);
    // request during take re-arms a second interrupt
    cyc(0,0,0,0,1,      1,'h2,0,'h40, 0,0);
    cyc(0,0,0,0,1,      1,'h3,0,'h40, 0,0);
    cyc(0,0,0,0,0,      0,0,1,'h3, 1,2);
    cyc(0,0,0,0,0,      0,0,0,'h3, 1,3);
    cyc(0,0,0,0,0,      0,0,0,'h3, 0,0);
    cyc(0,0,0,0,0,      1,'h300,0,'h3, 0,0);
    cyc(0,0,0,0,0,      0,0,1,'h300, 1,2);
    cyc(0,0,0,0,0,      0,0,0,'h300, 1,3);
    // asynchronous reset mid-ILOAD, observed before the next edge
    push(1, 0, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    push(1, 0, 0, 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    reset_vector_seq();
    cyc(0,0,0,0,0,      1,'h00AB1234,0,0, 0,0);
    armed = 1'b0;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL queue_drain: got %0d entries left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no end of stimulus, required completion by 20000");
    $fatal(1, "timeout");
  end

endmodule
